// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: shared dump FSM state type and default widths for the debug read-out blocks
package mips_dbg_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_READ,
        S_SEND,
        S_DONE
    } dump_state_t;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CYCLE_W = 32;
endpackage

// File: rtl/reg_dump_unit_if.sv
// reg_dump_unit_if: valid/ready register dump stream
// valid, index, pc, data flow master -> slave; ready flows slave -> master
interface reg_dump_unit_if
    import mips_dbg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              valid;
    logic              ready;
    logic              pc;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] data;
    modport master(output valid, index, pc, data, input ready);
    modport slave(input valid, index, pc, data, output ready);
endinterface

// File: rtl/run_limit_counter.sv
// run_limit_counter: saturating up-counter with clear, enable, loadable limit and terminal-count flag
// clk, rst_n: clock and async active-low reset
// clr: zero the count; load/load_val: latch a new limit; en: count one cycle
// count: current value (never wraps); tc: count == limit-1 (never set for limit 0)
module run_limit_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);
    logic [W-1:0] limit;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            limit <= '0;
        end else begin
            if (load) limit <= load_val;
            if (clr) count <= '0;
            else if (en && count != '1) count <= count + 1'b1;
        end
    end
    assign tc = limit != '0 && count == limit - 1'b1;
endmodule

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: runs the core for a set number of cycles, halts and drains it, then streams the register file out
// clk, rst_n: clock and async active-low reset
// start, cycle_limit: begin a run of cycle_limit cycles (honoured in IDLE/DONE)
// pc_in: core PC, captured on drain entry when REG_DUMP_PC_EN is defined (unused otherwise)
// halt: freezes the core; cycle_count: run cycles elapsed (saturating)
// rf_rd_addr, rf_rd_data: synchronous debug read port of the register file
// dump: valid/ready beat stream (index, pc flag, data); done: dump complete
// Optional feature: define REG_DUMP_PC_EN for a leading PC beat
module reg_dump_unit
    import mips_dbg_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int CYCLE_W      = DEF_CYCLE_W,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CYCLE_W-1:0] cycle_limit,
    input  logic [DATA_W-1:0]  pc_in,
    output logic               halt,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic [ADDR_W-1:0]  rf_rd_addr,
    input  logic [DATA_W-1:0]  rf_rd_data,
    output logic               done,
    reg_dump_unit_if.master    dump
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    dump_state_t       state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic              go, enter_drain, accept, cyc_tc, drn_tc, pc_beat;
    logic [DW-1:0]     unused_drn_count;
`ifdef REG_DUMP_PC_EN
    localparam bit PC_EN = 1'b1;
    logic [DATA_W-1:0] pc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            pc_beat <= 1'b0;
        end else begin
            if (enter_drain) pc_q <= pc_in;
            if (state == S_DRAIN && drn_tc) pc_beat <= 1'b1;
            else if (state == S_READ) pc_beat <= 1'b0;
        end
    end
`else
    localparam bit PC_EN = 1'b0;
    logic unused_pc;
    assign unused_pc = ^pc_in;
    assign pc_beat   = 1'b0;
`endif
    assign dump.pc     = pc_beat;
    assign go          = start && (state == S_IDLE || state == S_DONE);
    assign enter_drain = (go && cycle_limit == '0) || (state == S_RUN && cyc_tc);
    assign accept      = state == S_SEND && dump.ready;
    assign idx_next    = go ? '0 : (accept && !pc_beat && idx != LAST) ? idx + 1'b1 : idx;
    // The register file reads one cycle late, so the address runs one step ahead
    // of idx: data for idx is already on rf_rd_data during READ.
    assign rf_rd_addr  = idx_next;
    run_limit_counter #(.W(CYCLE_W)) u_cycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (go),
        .load     (go),
        .load_val (cycle_limit),
        .en       (state == S_RUN),
        .count    (cycle_count),
        .tc       (cyc_tc)
    );
    run_limit_counter #(.W(DW)) u_drain (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (enter_drain),
        .load     (enter_drain),
        .load_val (DW'(DRAIN_CYCLES)),
        .en       (state == S_DRAIN),
        .count    (unused_drn_count),
        .tc       (drn_tc)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (go) state_next = cycle_limit == '0 ? S_DRAIN : S_RUN;
            S_RUN:          if (cyc_tc) state_next = S_DRAIN;
            S_DRAIN:        if (drn_tc) state_next = PC_EN ? S_SEND : S_READ;
            S_READ:         state_next = S_SEND;
            S_SEND:         if (accept) state_next = (!pc_beat && idx == LAST) ? S_DONE : S_READ;
            default:        state_next = S_IDLE;
        endcase
    end
    always_comb begin
        halt       = !(state == S_IDLE || state == S_RUN);
        dump.valid = state == S_SEND;
        done       = state == S_DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            dump.index <= '0;
            dump.data  <= '0;
        end else begin
            idx <= idx_next;
            if (state == S_READ) begin
                dump.index <= idx;
                dump.data  <= rf_rd_data;
            end
`ifdef REG_DUMP_PC_EN
            else if (state == S_DRAIN && drn_tc) begin
                dump.index <= '0;
                dump.data  <= pc_q;
            end
`endif
        end
    end
endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: table-driven and randomized checks of reg_dump_unit against a beat-list reference model
module tb_reg_dump_unit;
    localparam int NR = 32;
`ifdef REG_DUMP_PC_EN
    localparam int PCEN = 1;
`else
    localparam int PCEN = 0;
`endif
    localparam int NB     = NR + PCEN;
    localparam int LAT    = 4 + PCEN + 2 * NR;
    localparam int BUDGET = 3000;
    typedef struct packed {
        logic        pc;
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;
    typedef struct {
        int limit;
        int rmode;
        bit rnd;
        int exp_run;
        int exp_beats;
        int exp_lat;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cycle_limit = '0;
    logic [31:0] pc_in = '0;
    logic        halt, done;
    logic [31:0] cycle_count;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [31:0] rf[NR];
    reg_dump_unit_if #(.ADDR_W(5), .DATA_W(32)) dif ();
    reg_dump_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cycle_limit (cycle_limit),
        .pc_in       (pc_in),
        .halt        (halt),
        .cycle_count (cycle_count),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .done        (done),
        .dump        (dif)
    );
    always #5 clk = ~clk;
    always @(posedge clk) rf_rd_data <= rf[rf_rd_addr];
    int    errors = 0;
    int    checks = 0;
    int    rmode = 0;
    int    tick = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    // Drives dump_ready on each falling edge and records every beat that will be
    // accepted on the following rising edge; a stalled beat must not change.
    initial begin
        logic  stall;
        beat_t prev;
        stall = 1'b0;
        prev = '0;
        dif.ready = 1'b0;
        forever begin
            @(negedge clk);
            tick++;
            case (rmode)
                0: dif.ready = 1'b1;
                1: dif.ready = (tick % 4 == 0);
                2: dif.ready = 1'($urandom_range(0, 1));
                3: dif.ready = got_q.size() < 10;
                default: dif.ready = 1'b0;
            endcase
            if (!rst_n) stall = 1'b0;
            else begin
                if (stall) begin
                    check("stall_valid", dif.valid, 1);
                    check("stall_beat", {dif.pc, dif.index, dif.data}, prev);
                end
                if (dif.valid && dif.ready) got_q.push_back({dif.pc, dif.index, dif.data});
                stall = dif.valid && !dif.ready;
                prev = {dif.pc, dif.index, dif.data};
            end
        end
    end
    task automatic fill_rf(bit rnd);
        for (int i = 0; i < NR; i++) rf[i] = rnd ? $urandom : 32'(4 * (i + 1));
        pc_in = rnd ? $urandom : 32'd64;
    endtask
    task automatic build_exp();
        exp_q.delete();
        got_q.delete();
        if (PCEN != 0) exp_q.push_back({1'b1, 5'd0, pc_in});
        for (int i = 0; i < NR; i++) begin
            logic [4:0] a;
            a = 5'(i);
            exp_q.push_back({1'b0, a, rf[i]});
        end
    endtask
    task automatic pulse_start(int lim);
        @(negedge clk);
        start = 1'b1;
        cycle_limit = 32'(lim);
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic compare_beats(int n);
        check("beat_count", got_q.size(), n);
        foreach (exp_q[i])
            if (i < got_q.size()) check($sformatf("beat%0d", i), got_q[i], exp_q[i]);
    endtask
    task automatic run_checks(int lim, int exp_run, int exp_beats, int exp_lat);
        int n;
        n = 0;
        while (!halt && n < BUDGET) begin
            n++;
            @(negedge clk);
        end
        check("unhalted_cycles", n, exp_run);
        check("count_at_halt", cycle_count, lim);
        n = 0;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("done", done, 1);
        if (exp_lat >= 0) check("halt_to_done", n, exp_lat);
        check("count_at_done", cycle_count, lim);
        check("halt_in_done", halt, 1);
        compare_beats(exp_beats);
    endtask
    initial begin
        vec_t  vt[6];
        beat_t held;
        int    n;
        vt[0] = '{16, 0, 1'b0, 16, NB, LAT};
        vt[1] = '{16, 1, 1'b1, 16, NB, -1};
        vt[2] = '{0, 0, 1'b1, 0, NB, LAT};
        vt[3] = '{1, 2, 1'b1, 1, NB, -1};
        vt[4] = '{37, 2, 1'b1, 37, NB, -1};
        vt[5] = '{3, 1, 1'b0, 3, NB, -1};
        fill_rf(1'b0);
        repeat (3) @(negedge clk);
        check("rst_halt", halt, 0);
        check("rst_valid", dif.valid, 0);
        check("rst_pc", dif.pc, 0);
        check("rst_done", done, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_rd_addr", rf_rd_addr, 0);
        check("rst_index", dif.index, 0);
        check("rst_data", dif.data, 0);
        rst_n = 1'b1;
        foreach (vt[k]) begin
            rmode = vt[k].rmode;
            fill_rf(vt[k].rnd);
            build_exp();
            pulse_start(vt[k].limit);
            run_checks(vt[k].limit, vt[k].exp_run, vt[k].exp_beats, vt[k].exp_lat);
        end
        rmode = 3;
        fill_rf(1'b1);
        build_exp();
        pulse_start(2);
        n = 0;
        while (!(dif.valid && got_q.size() == 10) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("reach_beat10", got_q.size(), 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_halt", halt, 0);
        check("mid_rst_valid", dif.valid, 0);
        check("mid_rst_pc", dif.pc, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cycle_count", cycle_count, 0);
        check("mid_rst_rd_addr", rf_rd_addr, 0);
        check("mid_rst_index", dif.index, 0);
        check("mid_rst_data", dif.data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rmode = 0;
        fill_rf(1'b0);
        build_exp();
        pulse_start(4);
        run_checks(4, 4, NB, LAT);
        rmode = 4;
        fill_rf(1'b1);
        build_exp();
        pulse_start(5);
        n = 0;
        while (!dif.valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        held = {dif.pc, dif.index, dif.data};
        pulse_start(99);
        @(negedge clk);
        check("send_start_valid", dif.valid, 1);
        check("send_start_beat", {dif.pc, dif.index, dif.data}, held);
        check("send_start_count", cycle_count, 5);
        check("send_start_halt", halt, 1);
        rmode = 0;
        n = 0;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("send_start_done", done, 1);
        compare_beats(NB);
        fill_rf(1'b1);
        build_exp();
        pulse_start(7);
        check("restart_done_clear", done, 0);
        check("restart_halt", halt, 0);
        check("restart_count", cycle_count, 0);
        run_checks(7, 7, NB, LAT);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Run-length controller and register-file read-out engine for the pipelined MIPS core. It lets the core run for a programmed number of clock cycles, then freezes it and drains the pipeline. It then reads every architectural register in index order and streams each value out over a valid/ready handshake. Downstream this feeds a debug port or a bench checker, so final register state no longer has to be probed hierarchically.

## Interface
- NUM_REGS, 32, registers dumped, indices 0..NUM_REGS-1
- DATA_W, 32, register and PC width
- ADDR_W, 5, register-file address width; 2**ADDR_W >= NUM_REGS
- CYCLE_W, 32, cycle counter and limit width
- DRAIN_CYCLES, 4, cycles between `halt` rising and the first register read
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE
- cycle_limit  in  CYCLE_W  run cycles before halt; sampled on accepted `start`
- pc_in  in  DATA_W  core program counter
- halt  out  1  stalls the core (PC and all pipeline registers hold)
- cycle_count  out  CYCLE_W  run cycles elapsed in the current run
- rf_rd_addr  out  ADDR_W  register-file debug read address
- rf_rd_data  in  DATA_W  read data, synchronous, one cycle after `rf_rd_addr`
- dump_valid  out  1  `dump_data` is valid
- dump_ready  in  1  consumer accepts the beat
- dump_index  out  ADDR_W  register index of the current beat
- dump_pc  out  1  current beat carries the PC (see Configuration)
- dump_data  out  DATA_W  beat payload
- done  out  1  dump complete; level, held until next `start`

## Operation
- States: IDLE, RUN, DRAIN, READ, SEND, DONE.
- IDLE → RUN on `start`:
  - `cycle_limit` is latched and `cycle_count` clears to 0.
  - If the latched limit is 0, go IDLE → DRAIN directly.
- RUN:
  - `cycle_count` increments each cycle and `halt` = 0.
  - When `cycle_count` reaches limit−1, the next edge enters DRAIN with `cycle_count` = limit.
- DRAIN:
  - `halt` = 1. The drain counter counts DRAIN_CYCLES cycles, then moves to READ.
  - The PC is captured into the PC register on DRAIN entry.
- READ: drives `rf_rd_addr` = idx for one cycle, then goes to SEND. `rf_rd_data` is registered into `dump_data` on that edge.
- SEND:
  - `dump_valid` = 1.
  - `dump_data`, `dump_index` and `dump_pc` stay stable until `dump_valid` & `dump_ready`.
  - On acceptance: if idx = NUM_REGS−1, go to DONE; otherwise idx++ and go to READ.
- DONE:
  - `done` = 1 and `halt` stays 1.
  - `start` re-enters RUN (or DRAIN if the limit is 0) with `done` cleared, idx reset and `cycle_count` cleared.
- `halt` = 1 in DRAIN, READ, SEND and DONE; 0 in IDLE and RUN.
- `start` in RUN, DRAIN, READ or SEND is ignored.
- `dump_ready` while `dump_valid` = 0 has no effect.
- `cycle_count` saturates; it never wraps.

## Timing
- Reset values: state IDLE; `halt`, `dump_valid`, `dump_pc` and `done` = 0; `cycle_count`, `rf_rd_addr`, `dump_index` and `dump_data` = 0.
- Reset mid-operation aborts immediately: `halt` drops and any beat in flight is lost.
- `start` at edge N: the core is un-halted for cycles N+1 .. N+limit, and `halt` rises at edge N+limit.
- First READ happens DRAIN_CYCLES cycles after `halt` rises.
- Each beat takes at least 2 cycles (READ + SEND). With `dump_ready` tied high, a full dump takes 2·NUM_REGS cycles.
- Back-pressure stretches SEND only.

## Configuration
- `REG_DUMP_PC_EN` defined:
  - One extra leading beat: `dump_pc` = 1, `dump_index` = 0, `dump_data` = PC captured on DRAIN entry.
  - That beat is sent from SEND without a READ cycle; register beats follow with `dump_pc` = 0.
- Not defined: no PC beat, `dump_pc` tied 0, `pc_in` unused, and the PC capture register is not instantiated.

## Structure
- Shared package `mips_dbg_pkg`: state enum `dump_state_t` and default widths for ADDR_W, DATA_W and CYCLE_W.
- One sub-module `run_limit_counter`: the saturating cycle counter with load, clear, enable and terminal-count flag. It is reused for the drain counter.

## Test plan
- Run cycle count:
  - Stimulus: model register file with R[i] = 4·(i+1); `start` with `cycle_limit` = 16, `dump_ready` = 1.
  - Required response: exactly 16 un-halted cycles, then `halt` = 1.
  - Required response: 32 beats in index order with data 4, 8, 12 … 128; `done` one cycle after the last beat; 64 cycles from first READ to `done`.
- Back-pressure: `dump_ready` toggling 1 cycle on / 3 cycles off → no beat lost or duplicated, and data stays stable while stalled.
- Zero limit: `cycle_limit` = 0 → `halt` rises on the edge after `start`, and `cycle_count` stays 0.
- Reset mid-SEND:
  - Stimulus: `rst_n` low during beat 10, then released.
  - Required response: all outputs return to reset values.
  - Required response: a fresh `start` dumps from index 0.
- PC beat (`REG_DUMP_PC_EN` on):
  - Stimulus: `pc_in` = 64 at halt.
  - Required response: first beat has `dump_pc` = 1 and data 64; 33 beats total.
- Restart behaviour:
  - `start` while in SEND → ignored.
  - `start` in DONE → new run; `done` clears on the next edge.
